reg_bank_arbiter: RTL and testbench

Round-robin write arbiter and register bank: NUM_REQ requesters share the single write port of a DEPTH x WIDTH flop-based register bank. One write per cycle, fair round-robin grant, valid/ready handshake per requester, and a combinational read port. Sits between independent control agents (sequencers, config masters) and shared state registers in the common library.

---
 rtl/reg_bank_arbiter_pkg.sv | 30 +++
 rtl/reg_bank_arbiter_rr_arbiter.sv | 33 +++
 rtl/reg_bank_arbiter.sv | 92 +++++++++
 tb/tb_reg_bank_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/reg_bank_arbiter_pkg.sv
// Shared helpers for the round-robin write arbiter and register bank:
// width functions for address/requester-index fields and a one-hot encoder.
package reg_bank_arbiter_pkg;

  // Widest requester vector the encoder accepts.
  localparam int MAX_REQ = 16;
  localparam int MAX_ID_W = 4;

  // Address width for a bank of 'depth' entries (at least one bit).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Requester-index width for 'n' requesters (at least one bit).
  function automatic int id_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // One-hot to binary index. OR-ing the indices of set bits is exact for a
  // one-hot input and returns zero for an all-zero input.
  function automatic logic [MAX_ID_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx |= MAX_ID_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/reg_bank_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: searches ptr, ptr+1, ... modulo N and
// grants the first active request. en low forces no grant.
module rr_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int PW = id_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o
);

  logic found;

  // Rotating priority search starting at the pointer.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_o = '0;
    found = 1'b0;
    if (en_i) begin
      for (int k = 0; k < N; k++) begin
        if (!found && req_i[(int'(ptr_i) + k) % N]) begin
          gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/reg_bank_arbiter.sv
// Round-robin write arbiter in front of a DEPTH x WIDTH flop register bank.
// One write per cycle, zero-latency grant, combinational read port.
module reg_bank_arbiter
  import reg_bank_arbiter_pkg::*;
#(
  parameter int                NUM_REQ     = 4,
  parameter int                WIDTH       = 8,
  parameter int                DEPTH       = 8,
  parameter logic [WIDTH-1:0]  RESET_VALUE = '0,
  localparam int               ADDR_W      = addr_w(DEPTH),
  localparam int               ID_W        = id_w(NUM_REQ)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_REQ-1:0]          req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr_i,
  input  logic [NUM_REQ*WIDTH-1:0]    req_data_i,
  output logic [NUM_REQ-1:0]          req_ready_o,
  input  logic [ADDR_W-1:0]           rd_addr_i,
  output logic [WIDTH-1:0]            rd_data_o,
  output logic [ID_W-1:0]             last_id_o,
  output logic                        last_valid_o
);

  logic [NUM_REQ-1:0] gnt;
  logic [ID_W-1:0]    gnt_idx;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [WIDTH-1:0]   wr_data;

  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    last_id_q, last_id_d;
  logic               last_valid_q, last_valid_d;
  logic [WIDTH-1:0]   bank_q [DEPTH];

  // Grant is blocked while reset is held so no handshake can occur.
  rr_arbiter #(.N(NUM_REQ), .PW(ID_W)) u_arb (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .en_i  (rst_n),
    .gnt_o (gnt)
  );

  assign req_ready_o = gnt;
  assign wr_en       = |gnt;
  assign gnt_idx     = ID_W'(onehot_to_idx(MAX_REQ'(gnt)));

  // Write mux: select the granted requester's address and data.
  assign wr_addr = req_addr_i[int'(gnt_idx)*ADDR_W +: ADDR_W];
  assign wr_data = req_data_i[int'(gnt_idx)*WIDTH  +: WIDTH];

  // Read mux straight from storage; a same-cycle write is not bypassed.
  assign rd_data_o = bank_q[rd_addr_i];

  assign last_id_o    = last_id_q;
  assign last_valid_o = last_valid_q;

  // Next pointer and commit status: advance past the winner on a commit.
  always_comb begin
    ptr_d        = ptr_q;
    last_id_d    = last_id_q;
    last_valid_d = wr_en;
    if (wr_en) begin
      last_id_d = gnt_idx;
      ptr_d     = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  // Pointer, status and bank registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register
      // samples pre-edge values regardless of statement order.
      ptr_q        <= '0;
      last_id_q    <= '0;
      last_valid_q <= 1'b0;
      // NOTE: the bank is reset entry by entry, which pins it to flops
      // rather than a RAM macro; callers rely on a known RESET_VALUE.
      for (int i = 0; i < DEPTH; i++) begin
        bank_q[i] <= RESET_VALUE;
      end
    end else begin
      ptr_q        <= ptr_d;
      last_id_q    <= last_id_d;
      last_valid_q <= last_valid_d;
      if (wr_en) begin
        bank_q[wr_addr] <= wr_data;
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_arbiter.sv
// Self-checking bench for reg_bank_arbiter (NUM_REQ=4, WIDTH=8, DEPTH=8):
// directed vector table, then randomized traffic against a reference model.
module tb_reg_bank_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int D  = 8;
  localparam int AW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*AW-1:0]   req_addr;
  logic [N*W-1:0]    req_data;
  logic [N-1:0]      req_ready;
  logic [AW-1:0]     rd_addr;
  logic [W-1:0]      rd_data;
  logic [1:0]        last_id;
  logic              last_valid;

  always #5 clk = ~clk;

  reg_bank_arbiter #(.NUM_REQ(N), .WIDTH(W), .DEPTH(D), .RESET_VALUE(8'h00)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid_i  (req_valid),
    .req_addr_i   (req_addr),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .rd_addr_i    (rd_addr),
    .rd_data_o    (rd_data),
    .last_id_o    (last_id),
    .last_valid_o (last_valid)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_bank [D];
  int           m_ptr;
  int           m_lid;
  logic         m_lv;

  // Winner: the first valid requester met when walking the ring from m_ptr.
  function automatic int model_grant(input logic rst, input logic [N-1:0] v);
    int order[$];
    if (!rst) return -1;
    for (int k = 0; k < N; k++) order.push_back((m_ptr + k) % N);
    foreach (order[j]) if (v[order[j]]) return order[j];
    return -1;
  endfunction

  // Sampled results of the last step.
  logic [N-1:0] s_ready;
  logic [W-1:0] s_rd;
  logic         s_lv;
  logic [1:0]   s_lid;
  int           m_g;
  logic [N-1:0] m_ready;
  logic [W-1:0] m_rd;

  // One clock: drive at negedge, sample combinational outputs, let the edge
  // happen, advance the model, sample registered outputs.
  task automatic step(input logic rst, input logic [N-1:0] v, input logic [N*AW-1:0] a,
                      input logic [N*W-1:0] d, input logic [AW-1:0] ra);
    @(negedge clk);
    rst_n = rst; req_valid = v; req_addr = a; req_data = d; rd_addr = ra;
    #1;
    s_ready = req_ready;
    s_rd    = rd_data;
    m_g     = model_grant(rst, v);
    m_ready = (m_g >= 0) ? N'(1 << m_g) : '0;
    m_rd    = m_bank[ra];
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < D; i++) m_bank[i] = 8'h00;
      m_ptr = 0; m_lid = 0; m_lv = 1'b0;
    end else if (m_g >= 0) begin
      m_bank[a[m_g*AW +: AW]] = d[m_g*W +: W];
      m_ptr = (m_g + 1) % N;
      m_lid = m_g;
      m_lv  = 1'b1;
    end else begin
      m_lv = 1'b0;
    end
    #1;
    s_lv  = last_valid;
    s_lid = last_id;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic [N-1:0]  v;
    logic [N*AW-1:0] a;
    logic [N*W-1:0]  d;
    logic [AW-1:0] ra;
    logic          chk_rd;
    logic [W-1:0]  exp_rd;
    logic [N-1:0]  exp_ready;
    logic          exp_lv;
    logic [1:0]    exp_lid;
  } vec_t;

  localparam int NV = 23;
  vec_t vt [NV];

  int gcount [N];

  logic [N-1:0]    r_val;
  logic [AW-1:0]   r_addr [N];
  logic [W-1:0]    r_data [N];
  logic [N*AW-1:0] pa;
  logic [N*W-1:0]  pd;
  logic [AW-1:0]   ra;
  logic            rr;

  initial begin
    rst_n = 1'b0; req_valid = '0; req_addr = '0; req_data = '0; rd_addr = '0;
    m_ptr = 0; m_lid = 0; m_lv = 1'b0;

    // Reset held two cycles with all requesters valid.
    vt[0]  = '{1'b0, 4'hF, 12'h0, 32'h0, 3'd0, 1'b0, 8'h00, 4'h0, 1'b0, 2'd0};
    vt[1]  = '{1'b0, 4'hF, 12'h0, 32'h0, 3'd7, 1'b1, 8'h00, 4'h0, 1'b0, 2'd0};
    // Single requester 2: addr 3, data A5; visible after the edge.
    vt[2]  = '{1'b1, 4'h4, {3'd0,3'd3,3'd0,3'd0}, {8'h00,8'hA5,8'h00,8'h00}, 3'd3, 1'b1, 8'h00, 4'h4, 1'b1, 2'd2};
    vt[3]  = '{1'b1, 4'h0, 12'h0, 32'h0, 3'd3, 1'b1, 8'hA5, 4'h0, 1'b0, 2'd2};
    // Wrap and skip: ptr=3, 0 and 1 valid -> 0 then 1.
    vt[4]  = '{1'b1, 4'h3, {3'd0,3'd0,3'd1,3'd0}, {8'h00,8'h00,8'h20,8'h10}, 3'd0, 1'b1, 8'h00, 4'h1, 1'b1, 2'd0};
    vt[5]  = '{1'b1, 4'h2, {3'd0,3'd0,3'd1,3'd0}, {8'h00,8'h00,8'h20,8'h10}, 3'd0, 1'b1, 8'h10, 4'h2, 1'b1, 2'd1};
    // Grant 3 to return ptr to 0.
    vt[6]  = '{1'b1, 4'h8, {3'd6,3'd0,3'd0,3'd0}, {8'h33,8'h00,8'h00,8'h00}, 3'd1, 1'b1, 8'h20, 4'h8, 1'b1, 2'd3};
    // Collision on addr 5: 1 writes 11 first, then 2 writes 22.
    vt[7]  = '{1'b1, 4'h6, {3'd0,3'd5,3'd5,3'd0}, {8'h00,8'h22,8'h11,8'h00}, 3'd5, 1'b1, 8'h00, 4'h2, 1'b1, 2'd1};
    vt[8]  = '{1'b1, 4'h4, {3'd0,3'd5,3'd5,3'd0}, {8'h00,8'h22,8'h11,8'h00}, 3'd5, 1'b1, 8'h11, 4'h4, 1'b1, 2'd2};
    vt[9]  = '{1'b1, 4'h0, 12'h0, 32'h0, 3'd5, 1'b1, 8'h22, 4'h0, 1'b0, 2'd2};
    // ptr=3: grant 3 so fairness starts from ptr=0.
    vt[10] = '{1'b1, 4'h8, {3'd3,3'd2,3'd1,3'd0}, {8'hC3,8'hC2,8'hC1,8'hC0}, 3'd6, 1'b1, 8'h33, 4'h8, 1'b1, 2'd3};
    // Fairness: all valid for 8 cycles -> 0,1,2,3,0,1,2,3.
    for (int i = 0; i < 8; i++) begin
      vt[11+i] = '{1'b1, 4'hF, {3'd3,3'd2,3'd1,3'd0}, {8'hC3,8'hC2,8'hC1,8'hC0}, 3'd0, 1'b1,
                   (i == 0) ? 8'h10 : 8'hC0, 4'(1 << (i % 4)), 1'b1, 2'(i % 4)};
    end
    // Reset mid-stream: requester 3 to addr 7 with FF is dropped.
    vt[19] = '{1'b0, 4'h8, {3'd7,3'd0,3'd0,3'd0}, {8'hFF,8'h00,8'h00,8'h00}, 3'd7, 1'b1, 8'h00, 4'h0, 1'b0, 2'd0};
    vt[20] = '{1'b0, 4'hF, {3'd7,3'd0,3'd0,3'd0}, {8'hFF,8'h00,8'h00,8'h00}, 3'd7, 1'b1, 8'h00, 4'h0, 1'b0, 2'd0};
    // ptr back to 0: with 1 and 3 valid, 1 wins; addr 0 shows reset value.
    vt[21] = '{1'b1, 4'hA, {3'd7,3'd0,3'd4,3'd0}, {8'hFF,8'h00,8'h5A,8'h00}, 3'd0, 1'b1, 8'h00, 4'h2, 1'b1, 2'd1};
    vt[22] = '{1'b1, 4'h0, 12'h0, 32'h0, 3'd7, 1'b1, 8'h00, 4'h0, 1'b0, 2'd1};

    foreach (gcount[i]) gcount[i] = 0;

    for (int k = 0; k < NV; k++) begin
      step(vt[k].rst, vt[k].v, vt[k].a, vt[k].d, vt[k].ra);
      check($sformatf("vec%0d req_ready", k), 32'(s_ready), 32'(vt[k].exp_ready));
      if (vt[k].chk_rd) check($sformatf("vec%0d rd_data", k), 32'(s_rd), 32'(vt[k].exp_rd));
      check($sformatf("vec%0d last_valid", k), 32'(s_lv), 32'(vt[k].exp_lv));
      check($sformatf("vec%0d last_id", k), 32'(s_lid), 32'(vt[k].exp_lid));
      if (k >= 11 && k <= 18) begin
        for (int i = 0; i < N; i++) if (s_ready[i]) gcount[i]++;
      end
    end
    for (int i = 0; i < N; i++) check($sformatf("fairness count req%0d", i), 32'(gcount[i]), 32'd2);

    // ---------------- randomized traffic ----------------
    // Pending requests hold addr/data until granted; reset drops them.
    r_val = '0;
    for (int i = 0; i < N; i++) begin r_addr[i] = '0; r_data[i] = '0; end
    for (int c = 0; c < 400; c++) begin
      rr = ($urandom_range(0, 39) != 0);
      for (int i = 0; i < N; i++) begin
        if (!r_val[i] && ($urandom_range(0, 1) == 1)) begin
          r_val[i]  = 1'b1;
          r_addr[i] = AW'($urandom_range(0, D - 1));
          r_data[i] = W'($urandom);
        end
        pa[i*AW +: AW] = r_addr[i];
        pd[i*W +: W]   = r_data[i];
      end
      ra = AW'($urandom_range(0, D - 1));
      step(rr, r_val, pa, pd, ra);
      check($sformatf("rand%0d req_ready", c), 32'(s_ready), 32'(m_ready));
      check($sformatf("rand%0d rd_data", c), 32'(s_rd), 32'(m_rd));
      check($sformatf("rand%0d last_valid", c), 32'(s_lv), 32'(m_lv));
      if (m_lv) check($sformatf("rand%0d last_id", c), 32'(s_lid), 32'(m_lid));
      if (!rr) r_val = '0;
      else if (m_g >= 0) r_val[m_g] = 1'b0;
    end

    // Final sweep of the whole bank with no requests.
    for (int i = 0; i < D; i++) begin
      step(1'b1, '0, '0, '0, AW'(i));
      check($sformatf("sweep addr%0d", i), 32'(s_rd), 32'(m_bank[i]));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
